// File: rtl/ctrl_pkg.sv
// Shared types and opcode/PC-select constants for the multi-cycle controller.
package ctrl_pkg;

  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_BRANCH} state_t;
  typedef enum logic [2:0] {CL_REG, CL_IMM, CL_MEM, CL_CJ, CL_UJ, CL_ILL} class_t;

  // Class prefixes, matched against the top bits of the opcode
  localparam logic [1:0] PFX_REG = 2'b00;
  localparam logic [1:0] PFX_IMM = 2'b01;
  localparam logic [2:0] PFX_MEM = 3'b100;
  localparam logic [2:0] PFX_CJ  = 3'b101;
  localparam logic [3:0] PFX_UJ  = 4'b1100;

  localparam logic [1:0] FN_STM = 2'b00;
  localparam logic [1:0] FN_LDM = 2'b01;

  localparam logic [2:0] PC_PLUS1  = 3'b001;
  localparam logic [2:0] PC_OFFSET = 3'b010;
  localparam logic [2:0] PC_CONST  = 3'b100;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode class decode from the top five opcode bits.
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [4:0] op_hi,
  output class_t     cls,
  output logic       is_load,
  output logic       is_store
);

  logic [3:0] pfx;
  logic [1:0] fn;

  assign pfx = op_hi[4:1];
  assign fn  = op_hi[1:0];

  always_comb begin
    cls      = CL_ILL;
    is_load  = 1'b0;
    is_store = 1'b0;
    if (pfx[3:2] == PFX_REG)      cls = CL_REG;
    else if (pfx[3:2] == PFX_IMM) cls = CL_IMM;
    else if (pfx[3:1] == PFX_MEM) begin
      // fn overlaps the low prefix bit; only two memory functions exist
      if (fn == FN_STM) begin
        cls      = CL_MEM;
        is_store = 1'b1;
      end else if (fn == FN_LDM) begin
        cls     = CL_MEM;
        is_load = 1'b1;
      end
    end
    else if (pfx[3:1] == PFX_CJ)  cls = CL_CJ;
    else if (pfx == PFX_UJ)       cls = CL_UJ;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM: fetch handshake, decode, exec/mem/branch sequencing.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] instruction,
  output logic                instr_ready,
  input  logic                cond_flag,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                sel_alusrc_reg,
  output logic                sel_alusrc_const,
  output logic [2:0]          pc_src,
  output logic                pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                rf_in_alu,
  output logic                rf_in_mem,
  output logic                rf_write_en,
  output logic                busy,
  output logic                illegal,
  output logic                timeout
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t              state, state_nxt;
  logic [OPCODE_W-1:0] ir;
  logic [CNT_W-1:0]    wait_cnt;
  class_t              cls;
  logic                is_load, is_store;
  logic                tmo_hit;

  opcode_classifier u_cls (
    .op_hi    (ir[OPCODE_W-1 -: 5]),
    .cls      (cls),
    .is_load  (is_load),
    .is_store (is_store)
  );

  assign tmo_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && instr_valid) ir <= instruction;
      if (state == ST_MEM && !mem_ready && !tmo_hit) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                           wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt        = state;
    instr_ready      = 1'b0;
    alu_op           = '0;
    sel_alusrc_reg   = 1'b0;
    sel_alusrc_const = 1'b0;
    pc_src           = '0;
    pc_write         = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    rf_in_alu        = 1'b0;
    rf_in_mem        = 1'b0;
    rf_write_en      = 1'b0;
    busy             = (state != ST_FETCH);
    illegal          = 1'b0;
    timeout          = 1'b0;
    case (state)
      ST_FETCH: begin
        // Gated by rst_n so the handshake is dead while reset is held
        instr_ready = rst_n;
        if (instr_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        alu_op = ir[ALU_OP_W-1:0];
        case (cls)
          CL_REG: begin sel_alusrc_reg = 1'b1; state_nxt = ST_EXEC; end
          CL_IMM: begin sel_alusrc_const = 1'b1; state_nxt = ST_EXEC; end
          CL_MEM: begin sel_alusrc_const = 1'b1; state_nxt = ST_MEM; end
          CL_CJ, CL_UJ: state_nxt = ST_BRANCH;
          default: begin
            illegal   = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PC_PLUS1;
            state_nxt = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        alu_op           = ir[ALU_OP_W-1:0];
        sel_alusrc_reg   = (cls == CL_REG);
        sel_alusrc_const = (cls == CL_IMM);
        rf_in_alu        = 1'b1;
        rf_write_en      = 1'b1;
        pc_write         = 1'b1;
        pc_src           = PC_PLUS1;
        state_nxt        = ST_FETCH;
      end
      ST_MEM: begin
        alu_op           = ir[ALU_OP_W-1:0];
        sel_alusrc_const = 1'b1;
        mem_write        = is_store;
        mem_read         = is_load;
        rf_in_mem        = is_load;
        // Completion takes priority over a coincident timeout
        if (mem_ready) begin
          rf_write_en = is_load;
          pc_write    = 1'b1;
          pc_src      = PC_PLUS1;
          state_nxt   = ST_FETCH;
        end else if (tmo_hit) begin
          timeout   = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_PLUS1;
          state_nxt = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_op    = ir[ALU_OP_W-1:0];
        pc_write  = 1'b1;
        rf_in_alu = 1'b1;
        if (cls == CL_UJ) pc_src = PC_CONST;
        else              pc_src = cond_flag ? PC_OFFSET : PC_PLUS1;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus randomized checks of the controller against a per-instruction cycle model.
module tb_multicycle_controller;

  localparam int MEM_T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [5:0] instruction;
  logic       instr_ready;
  logic       cond_flag;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       sel_alusrc_reg, sel_alusrc_const;
  logic [2:0] pc_src;
  logic       pc_write, mem_read, mem_write, rf_in_alu, rf_in_mem, rf_write_en;
  logic       busy, illegal, timeout;
  logic [17:0] obs;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  multicycle_controller #(.OPCODE_W(6), .ALU_OP_W(3), .MEM_TIMEOUT(MEM_T)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .cond_flag(cond_flag), .mem_ready(mem_ready),
    .alu_op(alu_op), .sel_alusrc_reg(sel_alusrc_reg), .sel_alusrc_const(sel_alusrc_const),
    .pc_src(pc_src), .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
    .rf_in_alu(rf_in_alu), .rf_in_mem(rf_in_mem), .rf_write_en(rf_write_en),
    .busy(busy), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign obs = {instr_ready, alu_op, sel_alusrc_reg, sel_alusrc_const, pc_src, pc_write,
                mem_read, mem_write, rf_in_alu, rf_in_mem, rf_write_en, busy, illegal, timeout};

  function automatic logic [17:0] vec(input logic rdy, input logic [2:0] alu, input logic sr,
      input logic sc, input logic [2:0] pcs, input logic pw, input logic mr, input logic mw,
      input logic ra, input logic rm, input logic rw, input logic b, input logic il,
      input logic to);
    return {rdy, alu, sr, sc, pcs, pw, mr, mw, ra, rm, rw, b, il, to};
  endfunction

  localparam logic [17:0] FETCH_V = 18'h20000;

  // 0 REG, 1 IMM, 2 STM, 3 LDM, 4 CJ, 5 UJ, 6 illegal
  function automatic int cls_of(input logic [5:0] op);
    int t, fn;
    t  = int'(op) / 4;
    fn = (int'(op) / 2) % 4;
    if (t < 4) return 0;
    if (t < 8) return 1;
    if (t == 8 || t == 9) return (fn == 0) ? 2 : (fn == 1) ? 3 : 6;
    if (t == 10 || t == 11) return 4;
    if (t == 12) return 5;
    return 6;
  endfunction

  task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
    chk_cnt++;
    assert (o === e) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Runs one instruction from FETCH to its pc_write cycle; n = MEM cycle that sees mem_ready (0 = never)
  task automatic run(input logic [5:0] op, input logic cond, input int n);
    int c;
    logic [2:0] a;
    logic [2:0] pcs;
    logic rdy, last;
    c = cls_of(op);
    a = op[2:0];
    @(negedge clk);
    cond_flag = cond; mem_ready = 1'b0;
    #1 chk("fetch", obs, FETCH_V);
    instr_valid = 1'b1; instruction = op;
    @(negedge clk);
    instr_valid = 1'b0; instruction = 6'($urandom); mem_ready = 1'($urandom);
    #1 chk("decode", obs, vec(0, a, c == 0, c == 1 || c == 2 || c == 3,
                              (c == 6) ? 3'b001 : 3'b000, c == 6, 0, 0, 0, 0, 0, 1, c == 6, 0));
    if (c == 0 || c == 1) begin
      @(negedge clk); #1;
      chk("exec", obs, vec(0, a, c == 0, c == 1, 3'b001, 1, 0, 0, 1, 0, 1, 1, 0, 0));
    end else if (c == 4 || c == 5) begin
      @(negedge clk); #1;
      pcs = (c == 5) ? 3'b100 : (cond ? 3'b010 : 3'b001);
      chk("branch", obs, vec(0, a, 0, 0, pcs, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    end else if (c == 2 || c == 3) begin
      for (int k = 1; k <= MEM_T; k++) begin
        @(negedge clk);
        rdy = (k == n);
        mem_ready = rdy;
        last = rdy || (k == MEM_T);
        #1 chk("mem", obs, vec(0, a, 0, 1, last ? 3'b001 : 3'b000, last, c == 3, c == 2,
                               0, c == 3, rdy && c == 3, 1, 0, last && !rdy));
        if (last) break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instruction = '0; cond_flag = 1'b0; mem_ready = 1'b0;
    #1 chk("reset", obs, 18'h0);
    @(negedge clk); @(negedge clk);
    #1 chk("reset_held", obs, 18'h0);
    rst_n = 1'b1;

    run(6'b000010, 1'b0, 0);            // REG add
    run(6'b010101, 1'b0, 0);            // IMM
    run(6'b100010, 1'b0, 3);            // LDM, ready on 3rd MEM cycle
    run(6'b100000, 1'b0, 0);            // STM timeout
    run(6'b100000, 1'b0, MEM_T);        // ready on timeout cycle: completion wins
    run(6'b101000, 1'b1, 0);            // CJ taken
    run(6'b101000, 1'b0, 0);            // CJ not taken
    run(6'b110000, 1'b1, 0);            // UJ
    run(6'b111000, 1'b0, 0);            // illegal class
    run(6'b100100, 1'b0, 0);            // illegal memory fn
    run(6'b110111, 1'b0, 0);            // illegal 1101

    // Reset during a load wait drops the request immediately
    @(negedge clk);
    #1 chk("fetch_pre_rst", obs, FETCH_V);
    instr_valid = 1'b1; instruction = 6'b100011;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("mem_pre_rst", obs, vec(0, 3'b011, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0));
    @(negedge clk);
    #1 chk("mem2_pre_rst", obs, vec(0, 3'b011, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0));
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_mem", obs, 18'h0);
    @(negedge clk); rst_n = 1'b1;
    run(6'b100001, 1'b0, 0);            // full timeout length shows the wait count cleared

    for (int i = 0; i < 60; i++)
      run(6'($urandom_range(0, 63)), 1'($urandom), $urandom_range(0, 6));

    @(negedge clk);
    #1 chk("final_fetch", obs, FETCH_V);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
